rgb_sinp_decode: RTL and testbench



---
 rtl/rgb_sinp_decode.sv | 114 +++++++++++
 tb/tb_rgb_sinp_decode.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_sinp_decode.sv
`default_nettype none
// ============================================================================
// Module   : rgb_sinp_decode
// Brief    : WS2812B-style input decoder: high-pulse width -> bit, long
//            stable level -> stream reset, each event as a 2-clock strobe.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_sinp_decode #(
  parameter int THRESH_CLKS   = 58,
  parameter int MIN_HIGH_CLKS = 10,
  parameter int RESET_CLKS    = 4800,
  parameter int CW            = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic strobe,
  output logic sbit_value,
  output logic stream_reset,
  output logic glitch
);

  localparam logic [CW-1:0] C_THRESH   = CW'(THRESH_CLKS);
  localparam logic [CW-1:0] C_MIN_HIGH = CW'(MIN_HIGH_CLKS);
  localparam logic [CW-1:0] C_RST_M2   = CW'(RESET_CLKS - 2);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [1:0]    C_SETTLED  = 2'd3;

  logic          r_sync1;
  logic          r_din_s;
  logic          r_prev;
  logic [CW-1:0] r_hi_cnt;
  logic [CW-1:0] r_stable_cnt;
  logic          r_reset_sent;
  logic [1:0]    r_settle;
  logic          r_strobe_hold;

  logic w_edge;
  logic w_rise;
  logic w_fall;
  logic w_settled;
  logic w_bit_evt;
  logic w_glitch_evt;
  logic w_rst_evt;

  assign w_edge       = r_din_s ^ r_prev;
  assign w_rise       = w_edge & r_din_s;
  assign w_fall       = w_edge & ~r_din_s;
  assign w_settled    = (r_settle == C_SETTLED);
  assign w_bit_evt    = w_fall & ~r_reset_sent & (r_hi_cnt >= C_MIN_HIGH);
  assign w_glitch_evt = w_fall & ~r_reset_sent & (r_hi_cnt < C_MIN_HIGH);
  assign w_rst_evt    = ~w_edge & ~r_reset_sent & w_settled &
                        (r_stable_cnt == C_RST_M2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b0;
      r_din_s       <= 1'b0;
      r_prev        <= 1'b0;
      r_hi_cnt      <= '0;
      r_stable_cnt  <= '0;
      r_reset_sent  <= 1'b0;
      r_settle      <= 2'd0;
      r_strobe_hold <= 1'b0;
      strobe        <= 1'b0;
      sbit_value    <= 1'b0;
      stream_reset  <= 1'b0;
      glitch        <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_din_s <= r_sync1;
      r_prev  <= r_din_s;

      if (!w_settled)
        r_settle <= r_settle + 2'd1;

      if (w_rise)
        r_hi_cnt <= C_ONE;
      else if (r_din_s && !w_edge && !(&r_hi_cnt))
        r_hi_cnt <= r_hi_cnt + C_ONE;

      // Deassertion of rst is treated like a level edge once the
      // synchroniser has filled, so the post-reset stream reset lands
      // at the same offset as one following a real edge.
      if (w_edge || !w_settled)
        r_stable_cnt <= '0;
      else if (!(&r_stable_cnt))
        r_stable_cnt <= r_stable_cnt + C_ONE;

      if (w_edge)
        r_reset_sent <= 1'b0;
      else if (w_rst_evt)
        r_reset_sent <= 1'b1;

      glitch <= w_glitch_evt;

      if (w_bit_evt) begin
        sbit_value    <= (r_hi_cnt >= C_THRESH);
        stream_reset  <= 1'b0;
        strobe        <= 1'b1;
        r_strobe_hold <= 1'b1;
      end else if (w_rst_evt) begin
        stream_reset  <= 1'b1;
        strobe        <= 1'b1;
        r_strobe_hold <= 1'b1;
      end else begin
        strobe        <= r_strobe_hold;
        r_strobe_hold <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_sinp_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_sinp_decode
// Brief    : Random and directed din waveforms checked cycle by cycle against
//            an event model derived from run lengths of the sampled input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_sinp_decode;

  localparam int THRESH_CLKS   = 58;
  localparam int MIN_HIGH_CLKS = 10;
  localparam int RESET_CLKS    = 4800;
  localparam int CW            = 13;
  localparam int N             = 70000;

  localparam int EV_NONE = 0;
  localparam int EV_BIT0 = 1;
  localparam int EV_BIT1 = 2;
  localparam int EV_RST  = 3;
  localparam int EV_GL   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic strobe, sbit_value, stream_reset, glitch;

  rgb_sinp_decode #(
    .THRESH_CLKS  (THRESH_CLKS),
    .MIN_HIGH_CLKS(MIN_HIGH_CLKS),
    .RESET_CLKS   (RESET_CLKS),
    .CW           (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .strobe      (strobe),
    .sbit_value  (sbit_value),
    .stream_reset(stream_reset),
    .glitch      (glitch)
  );

  always #5 clk = ~clk;

  // Index n: value driven before posedge n / output observed just after it.
  bit din_arr [N];
  bit rst_arr [N];
  int ev      [N];
  bit exp_stb [N];
  bit exp_val [N];
  bit exp_rr  [N];
  bit exp_gl  [N];
  int p = 0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv, input int cyc);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, expv);
    end
  endtask

  function automatic void append(input bit lvl, input int len, input bit r);
    for (int i = 0; i < len && p < N; i++) begin
      din_arr[p] = lvl;
      rst_arr[p] = r;
      p++;
    end
  endfunction

  function automatic void place(input int idx, input int kind, input int ep_end);
    if (idx < ep_end && idx < N)
      ev[idx] = kind;
  endfunction

  // One level run: start edge t0, length L, term=1 if the run ended by a level change.
  function automatic void do_run(input bit lvl, input int t0, input int L, input bit term, input int ep_end);
    if (!term || L >= RESET_CLKS)
      place(t0 + RESET_CLKS + 1, EV_RST, ep_end);
    if (term && lvl && L < RESET_CLKS) begin
      if (L >= MIN_HIGH_CLKS)
        place(t0 + L + 2, (L >= THRESH_CLKS) ? EV_BIT1 : EV_BIT0, ep_end);
      else
        place(t0 + L + 2, EV_GL, ep_end);
    end
  endfunction

  function automatic void build_expected();
    int n, r, e, t0, cnt;
    bit lvl, val, rr, g;
    for (int i = 0; i < N; i++) ev[i] = EV_NONE;
    n = 0;
    while (n < N) begin
      if (rst_arr[n]) begin
        n++;
      end else begin
        r = n;
        e = r;
        while (e < N && !rst_arr[e]) e++;
        lvl = din_arr[r];
        t0  = r;
        for (int k = r + 1; k < e; k++) begin
          if (din_arr[k] != lvl) begin
            do_run(lvl, t0, k - t0, 1'b1, e);
            lvl = din_arr[k];
            t0  = k;
          end
        end
        do_run(lvl, t0, e - t0, 1'b0, e);
        n = e;
      end
    end
    val = 0; rr = 0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      g = 0;
      if (rst_arr[i]) begin
        val = 0; rr = 0; cnt = 0;
      end else begin
        case (ev[i])
          EV_BIT0: begin val = 0; rr = 0; cnt = 2; end
          EV_BIT1: begin val = 1; rr = 0; cnt = 2; end
          EV_RST:  begin rr = 1; cnt = 2; end
          EV_GL:   g = 1;
          default: ;
        endcase
      end
      exp_stb[i] = (cnt > 0);
      if (cnt > 0) cnt--;
      exp_val[i] = val;
      exp_rr[i]  = rr;
      exp_gl[i]  = g;
    end
  endfunction

  initial begin
    int c, len;
    int bnd [4];
    bnd = '{9, 10, 57, 58};
    // Directed section
    append(0, 4, 1);
    append(0, 6000, 0);
    for (int i = 0; i < 24; i++) begin append(1, 38, 0); append(0, 82, 0); end
    append(1, 77, 0); append(0, 43, 0);
    append(1, 57, 0); append(0, 60, 0);
    append(1, 58, 0); append(0, 60, 0);
    append(1, 5, 0);  append(0, 60, 0);
    append(1, 10, 0); append(0, 60, 0);
    append(1, 5000, 0); append(0, 100, 0);
    append(1, 38, 0);   append(0, 82, 0);
    append(1, 39, 0);  append(1, 38, 1); append(0, 2, 1);
    append(0, 50, 0);
    append(1, 77, 0);  append(0, 50, 0);
    // Random section
    while (p < N - 6000) begin
      c = $urandom_range(0, 9);
      case (c)
        0:       append(1, $urandom_range(1, 9), 0);
        1, 2, 3: append(1, $urandom_range(10, 57), 0);
        4, 5, 6: append(1, $urandom_range(58, 300), 0);
        7:       append(1, bnd[$urandom_range(0, 3)], 0);
        8:       append(1, $urandom_range(4700, 5300), 0);
        default: append(0, $urandom_range(4700, 5300), 0);
      endcase
      len = $urandom_range(12, 150);
      append(0, len, 0);
    end
    while (p < N) append(0, 1, 0);

    build_expected();

    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      din = din_arr[n];
      rst = rst_arr[n];
      @(posedge clk);
      #1;
      check("strobe", strobe, exp_stb[n], n);
      check("glitch", glitch, exp_gl[n], n);
      check("sbit_value", sbit_value, exp_val[n], n);
      check("stream_reset", stream_reset, exp_rr[n], n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
